// File: rtl/video_pkg.sv
// Shared VGA types, default 640x480@60 timing and test-pattern colours.
// Test pattern colours are used only when VGA_TEST_PATTERN_EN is defined.
package video_pkg;

    typedef logic [11:0] rgb_t;
    typedef logic [10:0] coord_t;

    localparam int DEF_H_DISP  = 640;
    localparam int DEF_H_FP    = 16;
    localparam int DEF_H_RT    = 96;
    localparam int DEF_H_BP    = 48;
    localparam int DEF_V_DISP  = 480;
    localparam int DEF_V_FP    = 10;
    localparam int DEF_V_RT    = 2;
    localparam int DEF_V_BP    = 33;
    localparam int DEF_CLK_DIV = 4;
    localparam int DEF_SRC_LAT = 2;

    localparam int DEF_H_TOTAL = DEF_H_DISP + DEF_H_FP + DEF_H_RT + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_DISP + DEF_V_FP + DEF_V_RT + DEF_V_BP;

    localparam int BAR_W = 80;

    localparam rgb_t C_WHITE   = 12'hFFF;
    localparam rgb_t C_YELLOW  = 12'hFF0;
    localparam rgb_t C_CYAN    = 12'h0FF;
    localparam rgb_t C_GREEN   = 12'h0F0;
    localparam rgb_t C_MAGENTA = 12'hF0F;
    localparam rgb_t C_RED     = 12'hF00;
    localparam rgb_t C_BLUE    = 12'h00F;
    localparam rgb_t C_BLACK   = 12'h000;

    function automatic rgb_t bar_color(input logic [2:0] idx);
        unique case (idx)
            3'd0:    return C_WHITE;
            3'd1:    return C_YELLOW;
            3'd2:    return C_CYAN;
            3'd3:    return C_GREEN;
            3'd4:    return C_MAGENTA;
            3'd5:    return C_RED;
            3'd6:    return C_BLUE;
            default: return C_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/vga_timing_gen_sig_delay.sv
// sig_delay: DEPTH-stage x WIDTH-bit shift register, sync reset to RESET_VAL.
// DEPTH = 0 collapses to a plain wire.
module sig_delay #(
    parameter int                DEPTH     = 1,
    parameter int                WIDTH     = 1,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    generate
        if (DEPTH == 0) begin : g_wire
            logic w_unused;
            assign w_unused = clk ^ reset;
            assign o_q = i_d;
        end else begin : g_pipe
            logic [WIDTH-1:0] r_pipe [DEPTH];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) r_pipe[i] <= RESET_VAL;
                end else begin
                    r_pipe[0] <= i_d;
                    for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
                end
            end

            assign o_q = r_pipe[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: pixel divider, h/v counters, source-latency aligned syncs.
// Optional colour-bar test pattern enabled by defining VGA_TEST_PATTERN_EN.
module vga_timing_gen
    import video_pkg::*;
#(
    parameter int H_DISP  = DEF_H_DISP,
    parameter int H_FP    = DEF_H_FP,
    parameter int H_RT    = DEF_H_RT,
    parameter int H_BP    = DEF_H_BP,
    parameter int V_DISP  = DEF_V_DISP,
    parameter int V_FP    = DEF_V_FP,
    parameter int V_RT    = DEF_V_RT,
    parameter int V_BP    = DEF_V_BP,
    parameter int CLK_DIV = DEF_CLK_DIV,
    parameter int SRC_LAT = DEF_SRC_LAT
) (
    input  logic        clk,
    input  logic        reset,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic        pix_tick,
    output logic        sof,
    input  logic [11:0] rgb_in,
`ifdef VGA_TEST_PATTERN_EN
    input  logic        test_en,
`endif
    output logic        hsync,
    output logic        vsync,
    output logic        video_on,
    output logic [11:0] rgb_out
);

    localparam int H_TOTAL = H_DISP + H_FP + H_RT + H_BP;
    localparam int V_TOTAL = V_DISP + V_FP + V_RT + V_BP;
    localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0] r_div;
    logic          r_tick;
    coord_t        r_h;
    coord_t        r_v;

    logic [DW-1:0] w_div_next;
    logic          w_h_last;
    logic          w_v_last;
    logic          w_hs_n;
    logic          w_vs_n;
    logic          w_von;
    logic [2:0]    w_dly;
    rgb_t          w_pix;

    assign w_div_next = (r_div == DW'(CLK_DIV - 1)) ? '0 : r_div + 1'b1;
    assign w_h_last   = (r_h == coord_t'(H_TOTAL - 1));
    assign w_v_last   = (r_v == coord_t'(V_TOTAL - 1));

    // Tick is registered so it stays low in reset even when CLK_DIV = 1.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_div  <= '0;
            r_tick <= 1'b0;
            r_h    <= '0;
            r_v    <= '0;
        end else begin
            r_div  <= w_div_next;
            r_tick <= (w_div_next == DW'(CLK_DIV - 1));
            if (r_tick) begin
                if (w_h_last) begin
                    r_h <= '0;
                    r_v <= w_v_last ? '0 : r_v + 11'd1;
                end else begin
                    r_h <= r_h + 11'd1;
                end
            end
        end
    end

    assign x        = r_h;
    assign y        = r_v;
    assign pix_tick = r_tick;
    assign sof      = r_tick & w_h_last & w_v_last;

    assign w_hs_n = !((r_h >= coord_t'(H_DISP + H_FP)) &&
                      (r_h <= coord_t'(H_DISP + H_FP + H_RT - 1)));
    assign w_vs_n = !((r_v >= coord_t'(V_DISP + V_FP)) &&
                      (r_v <= coord_t'(V_DISP + V_FP + V_RT - 1)));
    assign w_von  = (r_h < coord_t'(H_DISP)) && (r_v < coord_t'(V_DISP));

    sig_delay #(
        .DEPTH     (SRC_LAT),
        .WIDTH     (3),
        .RESET_VAL (3'b110)
    ) u_flag_dly (
        .clk   (clk),
        .reset (reset),
        .i_d   ({w_hs_n, w_vs_n, w_von}),
        .o_q   (w_dly)
    );

`ifdef VGA_TEST_PATTERN_EN
    coord_t     w_x_d;
    logic [2:0] w_bar;

    sig_delay #(
        .DEPTH     (SRC_LAT),
        .WIDTH     (11),
        .RESET_VAL (11'd0)
    ) u_x_dly (
        .clk   (clk),
        .reset (reset),
        .i_d   (r_h),
        .o_q   (w_x_d)
    );

    assign w_bar = 3'(w_x_d / coord_t'(BAR_W));
    assign w_pix = test_en ? bar_color(w_bar) : rgb_in;
`else
    assign w_pix = rgb_in;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            hsync    <= 1'b1;
            vsync    <= 1'b1;
            video_on <= 1'b0;
            rgb_out  <= '0;
        end else begin
            hsync    <= w_dly[2];
            vsync    <= w_dly[1];
            video_on <= w_dly[0];
            rgb_out  <= w_dly[0] ? w_pix : 12'h000;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen on a shrunken raster so whole frames fit the run.
module tb_vga_timing_gen;

    localparam int HD = 40, HF = 4, HR = 6, HB = 5;
    localparam int VD = 6,  VF = 2, VR = 2, VB = 3;
    localparam int D  = 4,  L  = 2;
    localparam int HT = HD + HF + HR + HB;
    localparam int VT = VD + VF + VR + VB;
    localparam int FRAME = D * HT * VT;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] rgb_in = 12'h000;
    logic [10:0] x, y;
    logic        pix_tick, sof, hsync, vsync, video_on;
    logic [11:0] rgb_out;

    int compared = 0;
    int mismatched = 0;
    int age = 0;
    int cyc = 0;
    int last_sof = -1;
    int mode = 0;
    int k1 = 0, k2 = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_DISP (HD), .H_FP (HF), .H_RT (HR), .H_BP (HB),
        .V_DISP (VD), .V_FP (VF), .V_RT (VR), .V_BP (VB),
        .CLK_DIV(D),  .SRC_LAT(L)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .x        (x),
        .y        (y),
        .pix_tick (pix_tick),
        .sof      (sof),
        .rgb_in   (rgb_in),
`ifdef VGA_TEST_PATTERN_EN
        .test_en  (1'b0),
`endif
        .hsync    (hsync),
        .vsync    (vsync),
        .video_on (video_on),
        .rgb_out  (rgb_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s cyc=%0d age=%0d: got %0h expected %0h",
                   tag, cyc, age, obs, exp);
        end
    endtask

    function automatic logic [11:0] src(input int h, input int v);
        case (mode)
            0:       return {1'b0, 11'(h)};
            1:       return 12'hFFF;
            default: return 12'(h * k1) ^ 12'(v * k2);
        endcase
    endfunction

    // Position is derived from elapsed clocks since reset, not from DUT state.
    task automatic step();
        logic [11:0] samp;
        bit r, tk, sf, ehs, evs, evon;
        int h, v, ph, pv, p;
        samp = rgb_in;
        @(posedge clk);
        r = reset;
        #1;
        cyc++;
        if (r) begin
            age = 0;
            last_sof = -1;
            chk("rst_x", 32'(x), 0);
            chk("rst_y", 32'(y), 0);
            chk("rst_tick", 32'(pix_tick), 0);
            chk("rst_sof", 32'(sof), 0);
            chk("rst_hsync", 32'(hsync), 1);
            chk("rst_vsync", 32'(vsync), 1);
            chk("rst_von", 32'(video_on), 0);
            chk("rst_rgb", 32'(rgb_out), 0);
        end else begin
            age++;
            h  = (age / D) % HT;
            v  = (age / (D * HT)) % VT;
            tk = (age % D) == D - 1;
            sf = tk && h == HT - 1 && v == VT - 1;
            chk("x", 32'(x), 32'(h));
            chk("y", 32'(y), 32'(v));
            chk("pix_tick", 32'(pix_tick), 32'(tk));
            chk("sof", 32'(sof), 32'(sf));
            if (age >= L + 1) begin
                p    = age - L - 1;
                ph   = (p / D) % HT;
                pv   = (p / (D * HT)) % VT;
                ehs  = !(ph >= HD + HF && ph < HD + HF + HR);
                evs  = !(pv >= VD + VF && pv < VD + VF + VR);
                evon = ph < HD && pv < VD;
            end else begin
                ehs  = 1'b1;
                evs  = 1'b1;
                evon = 1'b0;
            end
            chk("hsync", 32'(hsync), 32'(ehs));
            chk("vsync", 32'(vsync), 32'(evs));
            chk("video_on", 32'(video_on), 32'(evon));
            chk("rgb_out", 32'(rgb_out), evon ? 32'(samp) : 32'd0);
            if (sof === 1'b1) begin
                if (last_sof >= 0) chk("sof_period", 32'(cyc - last_sof), 32'(FRAME));
                last_sof = cyc;
            end
        end
        if (!r && age >= 2) begin
            p = age - 2;
            rgb_in = src((p / D) % HT, (p / (D * HT)) % VT);
        end else begin
            rgb_in = 12'($urandom);
        end
    endtask

    initial begin
        repeat (3) step();
        reset = 1'b0;
        mode  = 0;
        repeat (FRAME + $urandom_range(0, 600)) step();

        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        mode  = 1;
        repeat (FRAME + 100) step();

        mode = 2;
        k1 = $urandom;
        k2 = $urandom;
        repeat (2 * FRAME + 200) step();

        repeat (3) begin
            reset = 1'b1;
            repeat ($urandom_range(1, 3)) step();
            reset = 1'b0;
            mode  = $urandom_range(0, 2);
            repeat ($urandom_range(50, 1500)) step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Produces the pixel coordinates x/y consumed by the pixel-source blocks (background, sprites) and receives their 12-bit RGB result. Generates 640x480@60 Hz VGA timing from the system clock via a pixel-tick divider. Delays hsync/vsync/video_on to match the fixed source pipeline latency, then blanks and registers the RGB for the DAC pins.

Parameters:
H_DISP, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_RT, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_DISP, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_RT, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
CLK_DIV, 4, clk cycles per pixel (100 MHz -> 25 MHz); must be >= 1
SRC_LAT, 2, clk-cycle latency of the attached pixel source from x/y to rgb_in

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
x  out  11  horizontal pixel counter, 0..H_TOTAL-1
y  out  11  vertical line counter, 0..V_TOTAL-1
pix_tick  out  1  one-clk pulse each pixel period
sof  out  1  one-clk start-of-frame pulse
rgb_in  in  12  RGB returned by the pixel source, SRC_LAT clks after x/y
hsync  out  1  active-low horizontal sync, aligned with rgb_out
vsync  out  1  active-low vertical sync, aligned with rgb_out
video_on  out  1  visible-region flag, aligned with rgb_out
rgb_out  out  12  blanked, registered RGB to the DAC

Behaviour:
- One clock (clk); reset is synchronous and active-high. All state is updated on posedge clk.
- Totals: H_TOTAL = H_DISP+H_FP+H_RT+H_BP (800); V_TOTAL = V_DISP+V_FP+V_RT+V_BP (525).
- Divider: counts 0..CLK_DIV-1 and wraps. pix_tick=1 when the divider equals CLK_DIV-1. With CLK_DIV=1, pix_tick is constantly 1 after reset.
- Horizontal counter: on pix_tick, h increments; it wraps H_TOTAL-1 -> 0.
- Vertical counter: increments only on pix_tick when h=H_TOTAL-1; it wraps V_TOTAL-1 -> 0.
- x = h and y = v are driven directly from the counter registers (zero extra latency). Both are 11 bits; upper bits are zero.
- sof=1 for exactly one clk: the clk in which pix_tick=1, h=H_TOTAL-1 and v=V_TOTAL-1. The next clk shows x=0, y=0.
- Raw flags, combinational from h/v:
  - hs_n=0 for h in [H_DISP+H_FP, H_DISP+H_FP+H_RT-1] (656..751).
  - vs_n=0 for v in [V_DISP+V_FP, V_DISP+V_FP+V_RT-1] (490..491).
  - von = (h<H_DISP) && (v<V_DISP).
- Alignment delay line: hs_n, vs_n and von pass through SRC_LAT clk-stage flops. The delay counts clk cycles, not pixel ticks.
- Output stage: one register stage on all outputs.
  - rgb_out <= von_d ? rgb_in : 12'h000
  - hsync <= hs_d; vsync <= vs_d; video_on <= von_d
  - Total latency from an x/y change to the matching outputs is SRC_LAT+1 clks.
- Reset values:
  - x=0, y=0, divider=0, pix_tick=0, sof=0
  - hsync=1, vsync=1, video_on=0, rgb_out=0
  - every delay-line stage set to its inactive value (hs=1, vs=1, von=0)
- Reset mid-frame: the counters restart at (0,0) on the next clk and the delay line is flushed. No partial sync pulse may appear after reset deasserts.
- SRC_LAT=0 is legal: the delay line degenerates to wires, leaving the single output register.

Optional Feature:
Macro VGA_TEST_PATTERN_EN.
- Defined: an additional input test_en (1 bit) is present. When test_en=1, rgb_in is ignored and the visible output is 8 vertical colour bars, each 80 px wide (bar index = delayed x[9:7]... using x/80 computed from x delayed by SRC_LAT). The bar sequence is FFF, FF0, 0FF, 0F0, F0F, F00, 00F, 000. Blanking is still applied.
- Undefined: the test_en port and its logic are absent; rgb_out behaves as specified above.

Decomposition:
- Package video_pkg holds:
  - typedef rgb_t (logic [11:0])
  - typedef coord_t (logic [10:0])
  - default 640x480 timing localparams and derived H_TOTAL/V_TOTAL
  - test-pattern colour constants
- One sub-module, sig_delay: a parameterized DEPTH x WIDTH shift register with synchronous reset to a RESET_VAL parameter. It is used for the hs/vs/von (and test-x) alignment.

Test Plan:
- Assert reset for 3 clks mid-frame, then release -> during reset hsync=vsync=1, video_on=0, rgb_out=0, x=y=0. The first pix_tick occurs on the 4th clk after release (CLK_DIV=4).
- Free-run one line -> pix_tick period is exactly 4 clks. x runs 0..799 and wraps, and y increments exactly once. hsync is low for 96 ticks (384 clks), beginning 3 clks after x becomes 656.
- Free-run two frames -> sof pulses are 1,680,000 clks apart. vsync is low for 2 lines (1,600 ticks), beginning 3 clks after y becomes 490.
- Model the source as a 2-flop pipe producing rgb={1'b0,x[10:0]} truncated to 12 bits -> at every clk with video_on=1, rgb_out equals the value the model produces from the x held 3 clks earlier.
- Hold rgb_in=12'hFFF constantly -> rgb_out=000 whenever video_on=0 (e.g. x=700, or y=500), and FFF for all visible pixels.
- With VGA_TEST_PATTERN_EN defined and test_en=1 -> x=0..79 gives FFF, x=80 gives FF0, x=560..639 gives 000, and rgb_in is ignored.
